// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    // Instruction presented to decode when IF/ID carries no real instruction.
    localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0000;

    // PC step between sequential instructions (PC is a word address).
    localparam logic [31:0] PC_INC = 32'd1;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_reg
//  Description : IF/ID pipeline register with flush, load, hold and NOP
//                insertion. Priority: flush > load > hold > bubble.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_id_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        load,
    input  logic        hold,
    input  logic [31:0] load_inst,
    input  logic [31:0] load_pc,
    output logic [31:0] inst_ID,
    output logic [31:0] pc_ID,
    output logic [31:0] pc_plus1_ID,
    output logic        valid_ID
);

    // Update the decode-facing register; flush and bubble both insert a NOP
    // but leave the PC fields untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_ID     <= NOP_INST;
            pc_ID       <= 32'd0;
            pc_plus1_ID <= 32'd1;
            valid_ID    <= 1'b0;
        end else if (flush) begin
            inst_ID  <= NOP_INST;
            valid_ID <= 1'b0;
        end else if (load) begin
            inst_ID     <= load_inst;
            pc_ID       <= load_pc;
            pc_plus1_ID <= load_pc + PC_INC;
            valid_ID    <= 1'b1;
        end else if (!hold) begin
            inst_ID  <= NOP_INST;
            valid_ID <= 1'b0;
        end
    end

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction-fetch stage. Holds the fetch PC, issues one
//                outstanding word-addressed request to instruction memory and
//                feeds decode through the IF/ID register. Handles decode
//                stalls and decode/execute redirects.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_id,
    input  logic        redirect_id,
    input  logic [31:0] target_id,
    input  logic        redirect_ex,
    input  logic [31:0] target_ex,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_ID,
    output logic [31:0] pc_ID,
    output logic [31:0] pc_plus1_ID,
    output logic        valid_ID
);

    fetch_state_t r_state;
    logic [31:0]  r_pc_f;
    logic [31:0]  r_req_pc;
    logic [31:0]  r_hold_inst;
    logic         r_discard;
    // Clears on reset and sets on the first clock after release, so the
    // request line stays low while rst_n is low without looking at rst_n
    // combinationally.
    logic         r_run;

    logic         w_redirect;
    logic [31:0]  w_target;
    logic         w_accept;
    logic         w_load;
    logic [31:0]  w_load_inst;

    // Execute-stage redirect is older in program order, so it wins.
    assign w_redirect = redirect_ex | redirect_id;
    assign w_target   = redirect_ex ? target_ex : target_id;

    assign imem_req  = r_run && (r_state == FETCH);
    assign imem_addr = r_pc_f;
    assign w_accept  = imem_req && imem_ready;

    // A fresh response goes straight to decode; a buffered one leaves HOLD.
    assign w_load = !w_redirect && !stall_id &&
                    (((r_state == WAIT) && imem_rvalid && !r_discard) ||
                     (r_state == HOLD));
    assign w_load_inst = (r_state == HOLD) ? r_hold_inst : imem_rdata;

    // Fetch sequencer: request, await response, park the word while decode
    // stalls; any redirect retargets the PC and squashes in-flight data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FETCH;
            r_pc_f      <= RESET_PC;
            r_req_pc    <= RESET_PC;
            r_hold_inst <= NOP_INST;
            r_discard   <= 1'b0;
            r_run       <= 1'b0;
        end else begin
            r_run <= 1'b1;
            case (r_state)
                FETCH: begin
                    if (w_accept) begin
                        r_req_pc  <= r_pc_f;
                        r_pc_f    <= r_pc_f + PC_INC;
                        r_discard <= w_redirect;
                        r_state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        r_discard <= 1'b0;
                        if (!r_discard && !w_redirect && stall_id) begin
                            r_hold_inst <= imem_rdata;
                            r_state     <= HOLD;
                        end else begin
                            r_state <= FETCH;
                        end
                    end else if (w_redirect) begin
                        r_discard <= 1'b1;
                    end
                end
                HOLD: begin
                    if (w_redirect || !stall_id) begin
                        r_state <= FETCH;
                    end
                end
                default: begin
                    r_state <= FETCH;
                end
            endcase
            // Redirect target overrides any sequential PC update above.
            if (w_redirect) begin
                r_pc_f <= w_target;
            end
        end
    end

    if_id_reg #(
        .NOP_INST (NOP_INST)
    ) u_if_id_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (w_redirect),
        .load        (w_load),
        .hold        (stall_id),
        .load_inst   (w_load_inst),
        .load_pc     (r_req_pc),
        .inst_ID     (inst_ID),
        .pc_ID       (pc_ID),
        .pc_plus1_ID (pc_plus1_ID),
        .valid_ID    (valid_ID)
    );

endmodule : fetch_stage
`default_nettype wire
